// File: rtl/regression_accumulator.sv
// regression_accumulator: accumulates n, sum x, sum y, sum x*x and sum x*y over a run of samples
// Sum widths are chosen so MAX_N maximum-value samples never overflow.
module regression_accumulator #(
   parameter int SAMPLE_W = 7,
   parameter int MAX_N    = 127
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [SAMPLE_W-1:0]     x_in,
   input  logic [SAMPLE_W-1:0]     y_in,
   input  logic                    in_valid,
   input  logic                    in_last,
   output logic                    in_ready,
   output logic [SAMPLE_W-1:0]     n_out,
   output logic [2*SAMPLE_W-1:0]   sum_x,
   output logic [2*SAMPLE_W-1:0]   sum_y,
   output logic [3*SAMPLE_W-1:0]   sum_xx,
   output logic [3*SAMPLE_W-1:0]   sum_xy,
   output logic                    busy,
   output logic                    done
);
   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
   localparam logic [SAMPLE_W-1:0] MAX_V = SAMPLE_W'(MAX_N);
   state_t                  state_q, state_d;
   logic [SAMPLE_W-1:0]     n_q, n_d, n_inc;
   logic [2*SAMPLE_W-1:0]   sx_q, sx_d, sy_q, sy_d, xx, xy;
   logic [3*SAMPLE_W-1:0]   sxx_q, sxx_d, sxy_q, sxy_d;
   logic                    take;
   // products kept at full double width before zero-extension into the wide sums
   assign xx    = {{SAMPLE_W{1'b0}}, x_in} * {{SAMPLE_W{1'b0}}, x_in};
   assign xy    = {{SAMPLE_W{1'b0}}, x_in} * {{SAMPLE_W{1'b0}}, y_in};
   assign n_inc = n_q + 1'b1;
   assign take  = (state_q == ACCUM) && in_valid;
   always_comb begin
      state_d = state_q;
      n_d     = n_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      sxx_d   = sxx_q;
      sxy_d   = sxy_q;
      if (state_q == IDLE && start) begin
         state_d = ACCUM;
         n_d     = '0;
         sx_d    = '0;
         sy_d    = '0;
         sxx_d   = '0;
         sxy_d   = '0;
      end else if (take) begin
         n_d     = n_inc;
         sx_d    = sx_q + {{SAMPLE_W{1'b0}}, x_in};
         sy_d    = sy_q + {{SAMPLE_W{1'b0}}, y_in};
         sxx_d   = sxx_q + {{SAMPLE_W{1'b0}}, xx};
         sxy_d   = sxy_q + {{SAMPLE_W{1'b0}}, xy};
         state_d = (in_last || n_inc == MAX_V) ? DONE : ACCUM;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         n_q     <= '0;
         sx_q    <= '0;
         sy_q    <= '0;
         sxx_q   <= '0;
         sxy_q   <= '0;
      end else begin
         state_q <= state_d;
         n_q     <= n_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         sxx_q   <= sxx_d;
         sxy_q   <= sxy_d;
      end
   end
   assign in_ready = (state_q == ACCUM);
   assign busy     = (state_q == ACCUM);
   assign done     = (state_q == DONE);
   assign n_out    = n_q;
   assign sum_x    = sx_q;
   assign sum_y    = sy_q;
   assign sum_xx   = sxx_q;
   assign sum_xy   = sxy_q;
endmodule

// File: tb/tb_regression_accumulator.sv
// tb_regression_accumulator: directed and randomized runs checked every cycle against a queue-based model
module tb_regression_accumulator;
   localparam int SW = 7;
   localparam int MN = 127;
   logic              clk = 0, rst = 1, start = 0, in_valid = 0, in_last = 0;
   logic [SW-1:0]     x_in = 0, y_in = 0;
   logic              in_ready, busy, done;
   logic [SW-1:0]     n_out;
   logic [2*SW-1:0]   sum_x, sum_y;
   logic [3*SW-1:0]   sum_xx, sum_xy;
   int tests = 0, fails = 0;
   int qx[$], qy[$];
   bit m_run = 0, m_done = 0;
   regression_accumulator #(.SAMPLE_W(SW), .MAX_N(MN)) dut (
      .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
      .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
      .n_out(n_out), .sum_x(sum_x), .sum_y(sum_y), .sum_xx(sum_xx),
      .sum_xy(sum_xy), .busy(busy), .done(done)
   );
   always #5 clk = ~clk;
   task automatic check(string nm, longint act, longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask
   // sums over every sample accepted so far in the current run
   function automatic longint msum(int k);
      longint s = 0;
      for (int i = 0; i < qx.size(); i++)
         s += (k == 0) ? qx[i] : (k == 1) ? qy[i] : (k == 2) ? qx[i] * qx[i] : qx[i] * qy[i];
      return s;
   endfunction
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_run = 0;
         m_done = 0;
         qx.delete();
         qy.delete();
      end else if (m_done) begin
         m_done = 0;
      end else if (m_run) begin
         if (in_valid) begin
            qx.push_back(int'(x_in));
            qy.push_back(int'(y_in));
            if (in_last || qx.size() == MN) begin
               m_run = 0;
               m_done = 1;
            end
         end
      end else if (start) begin
         qx.delete();
         qy.delete();
         m_run = 1;
      end
   end
   always @(negedge clk) if (!rst) begin
      check("n_out", n_out, qx.size());
      check("sum_x", sum_x, msum(0));
      check("sum_y", sum_y, msum(1));
      check("sum_xx", sum_xx, msum(2));
      check("sum_xy", sum_xy, msum(3));
      check("busy", busy, m_run);
      check("in_ready", in_ready, m_run);
      check("done", done, m_done);
   end
   task automatic step(bit st, bit v, bit l, int x, int y);
      start = st;
      in_valid = v;
      in_last = l;
      x_in = SW'(x);
      y_in = SW'(y);
      @(posedge clk);
      #1;
      start = 0;
      in_valid = 0;
      in_last = 0;
   endtask
   initial begin
      #12;
      check("rst_n", n_out, 0);
      check("rst_sum_xx", sum_xx, 0);
      check("rst_busy", busy, 0);
      check("rst_ready", in_ready, 0);
      check("rst_done", done, 0);
      @(posedge clk);
      #1 rst = 0;
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 1, 2);
      step(0, 1, 0, 2, 4);
      step(0, 1, 1, 3, 6);
      check("basic_done", done, 1);
      check("basic_n", n_out, 3);
      check("basic_sx", sum_x, 6);
      check("basic_sy", sum_y, 12);
      check("basic_sxx", sum_xx, 14);
      check("basic_sxy", sum_xy, 28);
      step(0, 0, 0, 0, 0);
      check("basic_done_clr", done, 0);
      check("basic_idle", busy, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < MN; i++) step(0, 1, 0, 127, 127);
      check("max_done", done, 1);
      check("max_n", n_out, 127);
      check("max_sx", sum_x, 16129);
      check("max_sy", sum_y, 16129);
      check("max_sxx", sum_xx, 2048383);
      check("max_sxy", sum_xy, 2048383);
      step(0, 1, 0, 127, 127);
      check("max_after_n", n_out, 127);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 5, 1);
      repeat (3) step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      check("gap_busy", busy, 1);
      check("gap_n", n_out, 1);
      step(0, 1, 1, 5, 1);
      check("gap_n2", n_out, 2);
      check("gap_sx", sum_x, 10);
      check("gap_sxy", sum_xy, 10);
      step(0, 0, 0, 0, 0);
      check("oor_ready", in_ready, 0);
      step(0, 1, 1, 9, 9);
      check("oor_n", n_out, 2);
      check("oor_sx", sum_x, 10);
      check("oor_sy", sum_y, 2);
      step(1, 0, 0, 0, 0);
      step(0, 1, 0, 4, 3);
      #2 rst = 1;
      #1;
      check("arst_n", n_out, 0);
      check("arst_sxy", sum_xy, 0);
      check("arst_busy", busy, 0);
      check("arst_done", done, 0);
      @(posedge clk);
      #1 rst = 0;
      step(0, 1, 1, 7, 7);
      check("arst_norestart", n_out, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 4, 3);
      check("arst_run_n", n_out, 1);
      check("arst_run_sxy", sum_xy, 12);
      step(0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      check("single_done", done, 1);
      check("single_n", n_out, 1);
      check("single_sxx", sum_xx, 0);
      for (int r = 0; r < 30; r++) begin
         repeat ($urandom_range(0, 3)) step(0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127), $urandom_range(0, 127));
         step(1, 0, 0, 0, 0);
         for (int c = 0; c < 400 && (m_run || m_done); c++) begin
            if (r % 7 == 3 && c == 5) begin
               #2 rst = 1;
               #3 rst = 0;
            end
            step($urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0,
                 (r % 5 != 0) && $urandom_range(0, 15) == 0,
                 $urandom_range(0, 127), $urandom_range(0, 127));
         end
      end
      repeat (2) step(0, 0, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
